// File: rtl/microwave_controle.sv
// Cook-cycle controller for a microwave oven: sequences the countdown counter's load and
// per-second enable, gates the magnetron on door and buttons, and sounds the end-of-cycle beep.
module microwave_controle #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BEEP_SEC      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_closed,
    input  logic       zero,
    output logic       load,
    output logic       enable,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_o
);

    localparam int BEEP_TICKS = BEEP_SEC * TICKS_PER_SEC;
    localparam int PW         = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

    localparam logic [PW-1:0] SEC_LAST  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] BEEP_LAST = PW'(BEEP_TICKS - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT         state_q;
    logic [PW-1:0] prescaler_q;
    logic          startPrev_q;
    logic          stopPrev_q;
    logic          load_q;
    logic          enable_q;
    logic          magOn_q;
    logic          beep_q;

    logic startPress;
    logic stopPress;

    // A press is the rising edge of the button level against the previous clock's sample.
    assign startPress = start_btn & ~startPrev_q;
    assign stopPress  = stop_btn  & ~stopPrev_q;

    // Pulses default low each cycle; every branch states the outputs of the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
            startPrev_q <= 1'b0;
            stopPrev_q  <= 1'b0;
            load_q      <= 1'b0;
            enable_q    <= 1'b0;
            magOn_q     <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            startPrev_q <= start_btn;
            stopPrev_q  <= stop_btn;
            load_q      <= 1'b0;
            enable_q    <= 1'b0;
            magOn_q     <= 1'b0;
            beep_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!stopPress && startPress && door_closed) begin
                        state_q <= CHECK;
                        load_q  <= 1'b1;
                    end
                end

                // An open door here parks the loaded count instead of heating with the door open.
                CHECK: begin
                    if (stopPress || zero) begin
                        state_q <= IDLE;
                    end else if (!door_closed) begin
                        state_q <= PAUSE;
                    end else begin
                        state_q     <= RUN;
                        prescaler_q <= '0;
                        magOn_q     <= 1'b1;
                    end
                end

                RUN: begin
                    if (stopPress) begin
                        state_q <= PAUSE;
                    end else if (zero) begin
                        state_q     <= DONE;
                        prescaler_q <= '0;
                        beep_q      <= 1'b1;
                    end else if (!door_closed) begin
                        state_q <= PAUSE;
                    end else begin
                        magOn_q <= 1'b1;
                        if (prescaler_q >= SEC_LAST) begin
                            prescaler_q <= '0;
                            enable_q    <= 1'b1;
                        end else begin
                            prescaler_q <= prescaler_q + PRE_ONE;
                        end
                    end
                end

                PAUSE: begin
                    if (stopPress) begin
                        state_q <= IDLE;
                    end else if (startPress && door_closed) begin
                        state_q     <= RUN;
                        prescaler_q <= '0;
                        magOn_q     <= 1'b1;
                    end
                end

                DONE: begin
                    if (stopPress || prescaler_q >= BEEP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        beep_q      <= 1'b1;
                        prescaler_q <= prescaler_q + PRE_ONE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    prescaler_q <= '0;
                end
            endcase
        end
    end

    assign load    = load_q;
    assign enable  = enable_q;
    assign mag_on  = magOn_q;
    assign beep    = beep_q;
    assign state_o = state_q;

endmodule
